// File: rtl/vco_phase_decoder_if.sv
// Phase-in / decimated-sample-out port bundle for the VCO phase decoder.
// The master side feeds phase words and consumes samples. The slave side is the decoder.
`timescale 1ns/1ps
interface vco_phase_decoder_if #(
  parameter int PHASE_WIDTH = 11,
  parameter int OUT_WIDTH   = 20
);
  logic                   en;
  logic [PHASE_WIDTH-1:0] phase_i;
  logic                   phase_valid_i;
  logic [OUT_WIDTH-1:0]   sample_o;
  logic                   sample_valid_o;
  logic                   sample_ready_i;
  logic                   overrun_o;

  modport master (
    output en, phase_i, phase_valid_i, sample_ready_i,
    input  sample_o, sample_valid_o, overrun_o
  );

  modport slave (
    input  en, phase_i, phase_valid_i, sample_ready_i,
    output sample_o, sample_valid_o, overrun_o
  );
endinterface

// File: rtl/vco_phase_decoder.sv
// VCO phase first-difference plus DECIM-sample accumulate-and-dump, with a one-deep valid/ready output.
// A sample is registered one cycle after its DECIM-th word. A result that completes while an untaken sample is stalled is dropped and flags overrun_o.
`timescale 1ns/1ps
module vco_phase_decoder #(
  parameter int PHASE_WIDTH = 11,
  parameter int DECIM       = 512,
  parameter int OUT_WIDTH   = 20
) (
  input  logic               clk,
  input  logic               rst,
  vco_phase_decoder_if.slave io
);
  localparam int CNT_W = $clog2(DECIM);

  typedef enum logic [1:0] {IDLE, PRIME, ACC} state_t;

  state_t                 state, state_nxt;
  logic [PHASE_WIDTH-1:0] prev, prev_nxt;
  logic [OUT_WIDTH-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [PHASE_WIDTH-1:0] delta;
  logic [OUT_WIDTH-1:0]   result;
  logic                   done;

  logic [OUT_WIDTH-1:0]   sample_q;
  logic                   sample_vld_q;
  logic                   overrun_q;

  // Modular subtraction handles the phase wrap without any special casing.
  assign delta = io.phase_i - prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      prev  <= prev_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    done      = 1'b0;
    result    = '0;
    case (state)
      IDLE: begin
        if (io.en) state_nxt = PRIME;
      end
      PRIME: begin
        if (!io.en) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end else if (io.phase_valid_i) begin
          state_nxt = ACC;
          prev_nxt  = io.phase_i;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ACC: begin
        if (!io.en) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end else if (io.phase_valid_i) begin
          prev_nxt = io.phase_i;
          if (cnt == CNT_W'(DECIM - 1)) begin
            done    = 1'b1;
            result  = acc + OUT_WIDTH'(delta);
            acc_nxt = '0;
            cnt_nxt = '0;
          end else begin
            acc_nxt = acc + OUT_WIDTH'(delta);
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A stalled sample is never overwritten; a handshake in the same cycle frees the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (done) begin
      if (!sample_vld_q || io.sample_ready_i) begin
        sample_q     <= result;
        sample_vld_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (sample_vld_q && io.sample_ready_i) begin
      sample_vld_q <= 1'b0;
    end
  end

  assign io.sample_o       = sample_q;
  assign io.sample_valid_o = sample_vld_q;
  assign io.overrun_o      = overrun_q;
endmodule

// File: tb/tb_vco_phase_decoder.sv
// Bench for vco_phase_decoder: a DECIM=512 instance with a sample scoreboard and a DECIM=4 instance driven from a cycle vector table.
`timescale 1ns/1ps
module tb_vco_phase_decoder;
  logic clk;
  logic rst_b;
  logic rst_s;

  int n_chk;
  int n_fail;
  int n_xfer;
  logic [19:0] sbq[$];

  vco_phase_decoder_if #(.PHASE_WIDTH(11), .OUT_WIDTH(20)) b_if ();
  vco_phase_decoder_if #(.PHASE_WIDTH(11), .OUT_WIDTH(20)) s_if ();

  vco_phase_decoder #(.PHASE_WIDTH(11), .DECIM(512), .OUT_WIDTH(20)) u_big (
    .clk (clk),
    .rst (rst_b),
    .io  (b_if.slave)
  );

  vco_phase_decoder #(.PHASE_WIDTH(11), .DECIM(4), .OUT_WIDTH(20)) u_small (
    .clk (clk),
    .rst (rst_s),
    .io  (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        v;
    logic [10:0] ph;
    logic        rdy;
    logic        vld;
    logic [19:0] smp;
    logic        ovr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic v, input int ph, input logic rdy,
                     input logic vld, input int smp, input logic ovr);
    vec_t t;
    t.rst = r; t.en = e; t.v = v; t.ph = 11'(ph); t.rdy = rdy;
    t.vld = vld; t.smp = 20'(smp); t.ovr = ovr;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle on the big instance; a transfer at this edge pops the scoreboard.
  task automatic step_b(input logic e, input logic v, input logic [10:0] ph, input logic rdy);
    logic [19:0] exp;
    b_if.en = e;
    b_if.phase_valid_i = v;
    b_if.phase_i = ph;
    b_if.sample_ready_i = rdy;
    if (b_if.sample_valid_o && rdy) begin
      n_xfer++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got sample %0d, expected no sample", b_if.sample_o);
      end else begin
        exp = sbq.pop_front();
        chk("sb_sample", 32'(b_if.sample_o), 32'(exp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    n_xfer = 0;
    rst_b = 1'b1;
    rst_s = 1'b1;
    b_if.en = 1'b0; b_if.phase_valid_i = 1'b0; b_if.phase_i = '0; b_if.sample_ready_i = 1'b1;
    s_if.en = 1'b0; s_if.phase_valid_i = 1'b0; s_if.phase_i = '0; s_if.sample_ready_i = 1'b1;

    // Small-instance vector table: rst, en, v, phase, ready | valid, sample, overrun after the edge.
    add(1,0,0,   0,1, 0, 0,0);
    add(0,1,0,   0,1, 0, 0,0);
    add(0,1,1,2040,1, 0, 0,0);
    add(0,1,1,2044,1, 0, 0,0);
    add(0,1,1,   0,1, 0, 0,0);
    add(0,1,1,   4,1, 0, 0,0);
    add(0,1,1,   8,1, 1,16,0);
    add(0,1,1,   8,1, 0,16,0);
    add(0,1,1,   8,1, 0,16,0);
    add(0,1,1,   8,1, 0,16,0);
    add(0,1,1,   8,1, 1, 0,0);
    add(0,1,0,   8,1, 0, 0,0);
    add(0,1,1,   9,0, 0, 0,0);
    add(0,1,1,  10,0, 0, 0,0);
    add(0,1,1,  11,0, 0, 0,0);
    add(0,1,1,  12,0, 1, 4,0);
    add(0,1,1,  14,0, 1, 4,0);
    add(0,1,1,  16,0, 1, 4,0);
    add(0,1,1,  18,0, 1, 4,0);
    add(0,1,1,  20,0, 1, 4,1);
    add(0,1,0,  20,1, 0, 4,1);
    add(0,1,0,  20,1, 0, 4,1);
    add(0,1,1,  25,1, 0, 4,1);
    add(0,1,0,  25,1, 0, 4,1);
    add(0,1,1,  30,1, 0, 4,1);
    add(0,1,0,  30,1, 0, 4,1);
    add(0,1,1,  35,1, 0, 4,1);
    add(0,1,0,  35,1, 0, 4,1);
    add(0,1,1,  40,1, 1,20,1);
    add(0,1,0,  40,1, 0,20,1);
    add(0,1,1,  41,0, 0,20,1);
    add(0,1,1,  42,0, 0,20,1);
    add(0,1,1,  43,0, 0,20,1);
    add(0,1,1,  44,0, 1, 4,1);
    add(0,1,1,  46,0, 1, 4,1);
    add(0,1,1,  48,0, 1, 4,1);
    add(0,1,1,  50,0, 1, 4,1);
    add(0,1,1,  52,1, 1, 8,1);
    add(0,1,0,  52,1, 0, 8,1);
    add(0,1,1,  53,0, 0, 8,1);
    add(0,1,1,  54,0, 0, 8,1);
    add(0,1,1,  55,0, 0, 8,1);
    add(0,1,1,  56,0, 1, 4,1);
    add(0,1,1,  57,0, 1, 4,1);
    add(0,1,1,  58,0, 1, 4,1);
    add(1,1,1,  59,0, 0, 0,0);
    add(0,1,1, 100,0, 0, 0,0);
    add(0,1,1, 101,0, 0, 0,0);
    add(0,1,1, 102,0, 0, 0,0);
    add(0,1,1, 103,0, 0, 0,0);
    add(0,1,1, 104,0, 0, 0,0);
    add(0,1,1, 105,0, 1, 4,0);
    add(0,1,0, 105,1, 0, 4,0);

    // Big instance: reset, then a continuous ramp of +3 per word.
    step_b(0, 0, 11'd0, 1);
    step_b(0, 0, 11'd0, 1);
    rst_b = 1'b0;
    chk("rst_vld", 32'(b_if.sample_valid_o), 0);
    chk("rst_smp", 32'(b_if.sample_o), 0);
    chk("rst_ovr", 32'(b_if.overrun_o), 0);

    step_b(1, 0, 11'd0, 1);
    for (int k = 0; k <= 1536; k++) begin
      step_b(1, 1, 11'(3 * k), 1);
      if (k > 0 && k % 512 == 0) sbq.push_back(20'd1536);
      if (k == 511) chk("ramp_no_early_vld", 32'(b_if.sample_valid_o), 0);
      if (k == 512) begin
        chk("ramp_first_vld", 32'(b_if.sample_valid_o), 1);
        chk("ramp_first_smp", 32'(b_if.sample_o), 1536);
      end
      if (k == 1024) chk("ramp_b2b_vld", 32'(b_if.sample_valid_o), 1);
    end
    step_b(1, 0, 11'd0, 1);
    chk("ramp_drain_vld", 32'(b_if.sample_valid_o), 0);
    chk("ramp_xfers", 32'(n_xfer), 3);
    chk("ramp_sb_empty", 32'(sbq.size()), 0);
    chk("ramp_ovr", 32'(b_if.overrun_o), 0);

    // Enable drop after 100 words of a window; the partial window must vanish.
    for (int k = 1; k <= 100; k++) step_b(1, 1, 11'(4608 + 7 * k), 1);
    step_b(0, 1, 11'd77, 1);
    chk("endrop_vld", 32'(b_if.sample_valid_o), 0);
    step_b(1, 1, 11'd500, 1);
    step_b(1, 1, 11'd1000, 1);
    for (int j = 1; j <= 512; j++) begin
      step_b(1, 1, 11'(1000 + 2 * j), 1);
      if (j < 512) begin
        if (b_if.sample_valid_o !== 1'b0) chk("endrop_no_early_vld", 32'(b_if.sample_valid_o), 0);
      end else begin
        sbq.push_back(20'd1024);
        chk("endrop_vld_at_512", 32'(b_if.sample_valid_o), 1);
        chk("endrop_smp", 32'(b_if.sample_o), 1024);
      end
    end
    step_b(1, 0, 11'd0, 1);
    chk("endrop_xfers", 32'(n_xfer), 4);
    chk("endrop_sb_empty", 32'(sbq.size()), 0);
    b_if.en = 1'b0;

    // Small instance: apply the table cycle by cycle.
    for (int i = 0; i < vq.size(); i++) begin
      rst_s = vq[i].rst;
      s_if.en = vq[i].en;
      s_if.phase_valid_i = vq[i].v;
      s_if.phase_i = vq[i].ph;
      s_if.sample_ready_i = vq[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_vld", i), 32'(s_if.sample_valid_o), 32'(vq[i].vld));
      chk($sformatf("vec%0d_smp", i), 32'(s_if.sample_o), 32'(vq[i].smp));
      chk($sformatf("vec%0d_ovr", i), 32'(s_if.overrun_o), 32'(vq[i].ovr));
    end
    rst_s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
